// File: rtl/quad_pkg.sv
// Shared types, defaults and the quadrature direction decoder.
package quad_pkg;

  typedef logic [1:0] ab_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2,
    DIR_ERR  = 2'd3
  } dir_t;

  localparam int DEF_FILTER_CYCLES     = 5000;
  localparam int DEF_COUNTS_PER_DETENT = 4;
  localparam int DEF_ACCEL_THRESHOLD   = 2500000;
  localparam int DEF_ACCEL_STEP        = 10;

  // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00; both bits changing is illegal.
  function automatic dir_t quad_dir(ab_t prev_ab, ab_t cur_ab);
    dir_t d;
    d = DIR_NONE;
    if (prev_ab != cur_ab) begin
      if ((prev_ab ^ cur_ab) == 2'b11) begin
        d = DIR_ERR;
      end else begin
        case ({prev_ab, cur_ab})
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: d = DIR_UP;
          default:                                d = DIR_DOWN;
        endcase
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder phase: 2-FF synchroniser followed by a stability filter.
// The filtered level only follows the synchronised level after it has
// differed for FILTER_CYCLES consecutive cycles.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic filt,
  output logic cnt_zero
);

  localparam int CW = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser shift and stability counter / filtered level update
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt     = filt_q;
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/quadrature_counter.sv
// Debounced 4x quadrature decoder producing a signed 32-bit detent
// position with a stb/ack handshake and a saturating error counter.
// Optional build macro QUAD_ACCEL_EN: detents arriving faster than
// ACCEL_THRESHOLD cycles apart step the position by ACCEL_STEP.
module quadrature_counter
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES     = DEF_FILTER_CYCLES,
  parameter int COUNTS_PER_DETENT = DEF_COUNTS_PER_DETENT,
  parameter int ACCEL_THRESHOLD   = DEF_ACCEL_THRESHOLD,
  parameter int ACCEL_STEP        = DEF_ACCEL_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        quad_a,
  input  logic        quad_b,
  output logic [31:0] position_out,
  output logic        position_out_stb,
  input  logic        position_out_ack,
  output logic [7:0]  error_count
);

  localparam logic signed [4:0] UP_LAST = 5'(COUNTS_PER_DETENT - 1);
  localparam logic signed [4:0] DN_LAST = 5'(1 - COUNTS_PER_DETENT);

  logic              filt_a, filt_b, zero_a, zero_b;
  ab_t               cur_ab;
  dir_t              dir;
  ab_t               prev_ab_q, prev_ab_d;
  logic              primed_q, primed_d;
  logic signed [4:0] sub_q, sub_d;
  logic [31:0]       pos_q, pos_d;
  logic              stb_q, stb_d;
  logic [7:0]        err_q, err_d;
  logic              step_up, step_dn;
  logic [31:0]       step_mag;

  quad_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_deb_a (
    .clk(clk), .rst(rst), .pin(quad_a), .filt(filt_a), .cnt_zero(zero_a)
  );

  quad_debounce #(.FILTER_CYCLES(FILTER_CYCLES)) u_deb_b (
    .clk(clk), .rst(rst), .pin(quad_b), .filt(filt_b), .cnt_zero(zero_b)
  );

  assign cur_ab = {filt_a, filt_b};

  // Priming, direction decode, sub-detent accumulation and error counting
  always_comb begin
    prev_ab_d = prev_ab_q;
    primed_d  = primed_q;
    sub_d     = sub_q;
    err_d     = err_q;
    step_up   = 1'b0;
    step_dn   = 1'b0;
    dir       = quad_dir(prev_ab_q, cur_ab);
    if (!primed_q) begin
      // Wait for both filters to be idle so prev_ab starts from a settled pair.
      if (zero_a && zero_b) begin
        prev_ab_d = cur_ab;
        primed_d  = 1'b1;
      end
    end else begin
      prev_ab_d = cur_ab;
      case (dir)
        DIR_UP: begin
          if (sub_q == UP_LAST) begin
            sub_d   = '0;
            step_up = 1'b1;
          end else begin
            sub_d = sub_q + 5'sd1;
          end
        end
        DIR_DOWN: begin
          if (sub_q == DN_LAST) begin
            sub_d   = '0;
            step_dn = 1'b1;
          end else begin
            sub_d = sub_q - 5'sd1;
          end
        end
        DIR_ERR: begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef QUAD_ACCEL_EN
  localparam int IW = $clog2(ACCEL_THRESHOLD + 1);
  localparam logic [IW-1:0] IVL_SAT = IW'(ACCEL_THRESHOLD);

  logic [IW-1:0] ivl_q, ivl_d;

  // Cycles since the previous detent, saturating; picks the step size
  always_comb begin
    ivl_d = ivl_q;
    if (step_up || step_dn) begin
      ivl_d = '0;
    end else if (ivl_q != IVL_SAT) begin
      ivl_d = ivl_q + 1'b1;
    end
    step_mag = (ivl_q < IVL_SAT) ? 32'(ACCEL_STEP) : 32'd1;
  end

  // Interval register; starts saturated so the first detent is never accelerated
  always_ff @(posedge clk) begin
    if (rst) ivl_q <= IVL_SAT;
    else     ivl_q <= ivl_d;
  end
`else
  logic unused_accel;
  assign unused_accel = ^{ACCEL_THRESHOLD, ACCEL_STEP};
  assign step_mag     = 32'd1;
`endif

  // Position update (wrapping) and pending-change handshake
  always_comb begin
    pos_d = pos_q;
    if (step_up)      pos_d = pos_q + step_mag;
    else if (step_dn) pos_d = pos_q - step_mag;
    stb_d = step_up | step_dn | (stb_q & ~position_out_ack);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab_q <= 2'b00;
      primed_q  <= 1'b0;
      sub_q     <= '0;
      pos_q     <= '0;
      stb_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      prev_ab_q <= prev_ab_d;
      primed_q  <= primed_d;
      sub_q     <= sub_d;
      pos_q     <= pos_d;
      stb_q     <= stb_d;
      err_q     <= err_d;
    end
  end

  assign position_out     = pos_q;
  assign position_out_stb = stb_q;
  assign error_count      = err_q;

endmodule

// File: tb/tb_quadrature_counter.sv
// Bench for quadrature_counter: vector table, hand-timed corner cases
// and a randomized run against a behavioural model of the encoder.
module tb_quadrature_counter;

  localparam int F   = 4;
  localparam int CPD = 4;
`ifdef QUAD_ACCEL_EN
  localparam int AT    = 100;
  localparam int AS    = 10;
  localparam int HOLD  = 40;
  localparam bit ACCEL = 1'b1;
`else
  localparam int AT    = 2500000;
  localparam int AS    = 10;
  localparam int HOLD  = 10;
  localparam bit ACCEL = 1'b0;
`endif
  // Pin set just after edge E0 completes a detent on edge E0+F+3.
  localparam int LAT = F + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        quad_a = 1'b0;
  logic        quad_b = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] pos;
  logic        stb;
  logic [7:0]  err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  quadrature_counter #(
    .FILTER_CYCLES(F), .COUNTS_PER_DETENT(CPD),
    .ACCEL_THRESHOLD(AT), .ACCEL_STEP(AS)
  ) dut (
    .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b),
    .position_out(pos), .position_out_stb(stb),
    .position_out_ack(ack), .error_count(err)
  );

  typedef struct {
    logic [1:0]  ab;
    int          hold;
    logic        ack;
    logic [31:0] pos;
    logic        stb;
    logic [7:0]  err;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] epos, input logic estb, input logic [7:0] eerr);
    check({name, ".pos"}, pos, epos);
    check({name, ".stb"}, {31'd0, stb}, {31'd0, estb});
    check({name, ".err"}, {24'd0, err}, {24'd0, eerr});
  endtask

  task automatic set_ab(input logic [1:0] ab);
    quad_a = ab[1];
    quad_b = ab[0];
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ack = 1'b0;
    set_ab(2'b00);
    hold(3);
    check_all("reset", 32'd0, 1'b0, 8'd0);
    rst = 1'b0;
  endtask

  task automatic add(input logic [1:0] ab, input int h, input logic a,
                     input logic [31:0] p, input logic s, input logic [7:0] e);
    vec_t v;
    v.ab = ab; v.hold = h; v.ack = a; v.pos = p; v.stb = s; v.err = e;
    vt.push_back(v);
  endtask

  task automatic fwd_detent(input int h);
    set_ab(2'b01); hold(h);
    set_ab(2'b11); hold(h);
    set_ab(2'b10); hold(h);
    set_ab(2'b00); hold(h);
  endtask

  logic [1:0] gray [4];
  logic [1:0] rev  [4];

  initial begin
    int m_idx, m_sub, m_err, m_last, d_edge, dir, step, r, glen, nidx;
    logic [31:0] m_pos;
    logic        m_stb;
    logic [1:0]  mask;

    gray = '{2'b00, 2'b01, 2'b11, 2'b10};
    rev  = '{2'b10, 2'b11, 2'b01, 2'b00};

    // Vector table
    add(2'b01, HOLD, 1'b0, 32'd0, 1'b0, 8'd0);
    add(2'b11, HOLD, 1'b0, 32'd0, 1'b0, 8'd0);
    add(2'b10, HOLD, 1'b0, 32'd0, 1'b0, 8'd0);
    add(2'b00, HOLD, 1'b0, 32'd1, 1'b1, 8'd0);
    add(2'b00, 2,    1'b1, 32'd1, 1'b0, 8'd0);
    for (int k = 1; k <= 12; k++)
      add(rev[(k-1)%4], HOLD, 1'b0, 32'(1 - k/4), (k >= 4), 8'd0);
    add(2'b10, 2,    1'b0, 32'hFFFF_FFFE, 1'b1, 8'd0);
    add(2'b00, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b1, 8'd0);
    add(2'b00, 2,    1'b1, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b01, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b11, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b10, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b11, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b01, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b00, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b01, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b11, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b10, HOLD, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0);
    add(2'b00, HOLD, 1'b0, 32'hFFFF_FFFF, 1'b1, 8'd0);
    add(2'b11, HOLD, 1'b0, 32'hFFFF_FFFF, 1'b1, 8'd1);
    add(2'b00, HOLD, 1'b0, 32'hFFFF_FFFF, 1'b1, 8'd2);

    do_reset();
    foreach (vt[i]) begin
      set_ab(vt[i].ab);
      ack = vt[i].ack;
      hold(vt[i].hold);
      ack = 1'b0;
      check_all($sformatf("vec%0d", i), vt[i].pos, vt[i].stb, vt[i].err);
    end

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      set_ab(2'b11); hold(8);
      set_ab(2'b00); hold(8);
    end
    check_all("err_sat", 32'hFFFF_FFFF, 1'b1, 8'd255);

    // Detent completing on the same edge as ack keeps stb high
    set_ab(2'b01); hold(HOLD);
    set_ab(2'b11); hold(HOLD);
    set_ab(2'b10); hold(HOLD);
    set_ab(2'b00); hold(LAT - 1);
    check_all("ack_edge_before", 32'hFFFF_FFFF, 1'b1, 8'd255);
    ack = 1'b1; hold(1); ack = 1'b0;
    check_all("ack_edge_after", 32'd0, 1'b1, 8'd255);
    hold(3);
    check_all("ack_edge_hold", 32'd0, 1'b1, 8'd255);
    ack = 1'b1; hold(1); ack = 1'b0;
    check_all("ack_clear", 32'd0, 1'b0, 8'd255);

    // Reset mid-detent discards the partial count and pending stb
    fwd_detent(HOLD);
    check_all("pre_rst", 32'd1, 1'b1, 8'd255);
    set_ab(2'b01); hold(HOLD);
    set_ab(2'b11); hold(HOLD);
    do_reset();
    set_ab(2'b01); hold(HOLD);
    set_ab(2'b11); hold(HOLD);
    set_ab(2'b10); hold(HOLD);
    check_all("post_rst_3", 32'd0, 1'b0, 8'd0);
    set_ab(2'b00); hold(HOLD);
    check_all("post_rst_4", 32'd1, 1'b1, 8'd0);

    // Detent spacing: close pair, then a long gap
    do_reset();
    fwd_detent(12);
    check("spacing_1", pos, 32'd1);
    fwd_detent(12);
    check("spacing_2", pos, ACCEL ? 32'd11 : 32'd2);
    hold(160);
    fwd_detent(12);
    check("spacing_3", pos, ACCEL ? 32'd12 : 32'd3);

    // Randomized moves against the behavioural model
    do_reset();
    m_idx = 0; m_sub = 0; m_err = 0; m_last = -1; m_pos = 32'd0; m_stb = 1'b0;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        ack = 1'b1; hold(1); ack = 1'b0;
        m_stb = 1'b0;
      end
      r = $urandom_range(9, 0);
      if (r == 9) begin
        mask = ($urandom_range(1, 0) == 1) ? 2'b10 : 2'b01;
        glen = $urandom_range(F - 1, 1);
        set_ab(gray[m_idx] ^ mask); hold(glen);
        set_ab(gray[m_idx]); hold(10);
      end else begin
        dir  = (r < 4) ? 1 : (r < 8) ? -1 : 2;
        nidx = (m_idx + dir + 4) % 4;
        set_ab(gray[nidx]);
        d_edge = cyc + LAT;
        hold(10);
        m_idx = nidx;
        if (dir == 2) begin
          if (m_err < 255) m_err++;
        end else begin
          m_sub += dir;
          if (m_sub == CPD || m_sub == -CPD) begin
            m_sub = 0;
            step = (ACCEL && m_last >= 0 && (d_edge - m_last - 1) < AT) ? AS : 1;
            m_pos = m_pos + 32'(dir * step);
            m_stb = 1'b1;
            m_last = d_edge;
          end
        end
      end
      check_all($sformatf("rand%0d", it), m_pos, m_stb, 8'(m_err));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
